tof_mem_write_arb: RTL

TOF_MEM_WRITE_ARB -- requirements
Module: tof_mem_write_arb

---
 rtl/tof_mem_pkg.sv | 18 +
 rtl/tof_rr_arbiter.sv | 30 +++
 rtl/tof_mem_write_arb.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tof_mem_pkg.sv
// ToF memory write arbiter: shared FSM state type and default sizing.
// Optional macro TOF_MEM_WR_WRAP_FLAG_EN adds sticky per-channel wrap flags.
package tof_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam int DEF_N_CH      = 8;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_SLOTS     = 16;
  localparam int DEF_WE_CYCLES = 2;
  localparam int DEF_ADDR_W    = 8;

endpackage

// File: rtl/tof_rr_arbiter.sv
// Single-cycle round-robin scan over the request vector.
// Search begins one past the last granted channel and wraps modulo N_CH.
module tof_rr_arbiter #(
  parameter int N_CH = 8
) (
  input  logic [N_CH-1:0]         i_req,
  input  logic [$clog2(N_CH)-1:0] i_last,
  output logic [$clog2(N_CH)-1:0] o_gnt,
  output logic                    o_valid
);

  localparam int IW = $clog2(N_CH);

  // Scan farthest-first so the nearest requester after i_last wins
  always_comb begin
    int j;
    j       = 0;
    o_gnt   = '0;
    o_valid = 1'b0;
    for (int i = N_CH; i >= 1; i--) begin
      j = int'(i_last) + i;
      if (j >= N_CH) j = j - N_CH;
      if (i_req[j]) begin
        o_gnt   = IW'(j);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tof_mem_write_arb.sv
// Round-robin arbiter writing ToF channel samples into per-channel rings.
// Optional macro TOF_MEM_WR_WRAP_FLAG_EN adds wrap_flag / wrap_clr ports.
module tof_mem_write_arb
  import tof_mem_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SLOTS     = DEF_SLOTS,
  parameter int WE_CYCLES = DEF_WE_CYCLES,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_CH-1:0]          ch_dr,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [N_CH-1:0]          ch_ack,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  output logic [$clog2(N_CH)-1:0]  ch_index,
  output logic                     busy
`ifdef TOF_MEM_WR_WRAP_FLAG_EN
  ,
  output logic [N_CH-1:0]          wrap_flag,
  input  logic [N_CH-1:0]          wrap_clr
`endif
);

  localparam int IW = $clog2(N_CH);
  localparam int PW = $clog2(SLOTS);

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_ch;
  logic [IW-1:0]     r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [PW-1:0]     r_ptr [N_CH];
  logic [N_CH-1:0]   r_mask;
  logic [2:0]        r_cnt;

  logic [N_CH-1:0]   w_req;
  logic [IW-1:0]     w_gnt;
  logic              w_gvalid;
  logic              w_we_done;
  logic [N_CH-1:0]   w_onehot;
  logic [ADDR_W-1:0] w_addr;

  assign w_req     = ch_dr & ~r_mask;
  assign w_we_done = (r_cnt == 3'(WE_CYCLES - 1));
  assign w_onehot  = N_CH'(1) << r_ch;
  assign w_addr    = ADDR_W'(w_gnt) * ADDR_W'(SLOTS)
                   + ADDR_W'(r_ptr[w_gnt]);

  tof_rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_valid (w_gvalid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; unknown encodings fall back to IDLE
  always_comb begin
    w_next = IDLE;
    unique case (r_state)
      IDLE:    w_next = w_gvalid ? WRITE : IDLE;
      WRITE:   w_next = w_we_done ? ACK : HOLD;
      HOLD:    w_next = w_we_done ? ACK : HOLD;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    mem_we = 1'b0;
    busy   = 1'b1;
    ch_ack = '0;
    unique case (r_state)
      IDLE:    busy   = 1'b0;
      WRITE:   mem_we = 1'b1;
      HOLD:    mem_we = 1'b1;
      ACK:     ch_ack = w_onehot;
      default: busy   = 1'b0;
    endcase
  end

  // Grant capture, write-enable counter, pointer and priority update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ch   <= '0;
      r_last <= IW'(N_CH - 1);
      r_addr <= '0;
      r_din  <= '0;
      r_mask <= '0;
      r_cnt  <= '0;
      for (int k = 0; k < N_CH; k++) r_ptr[k] <= '0;
    end else begin
      r_mask <= '0;
      if (r_state == IDLE) r_cnt <= '0;
      else                 r_cnt <= r_cnt + 3'd1;
      if (r_state == IDLE && w_gvalid) begin
        r_ch   <= w_gnt;
        r_addr <= w_addr;
        r_din  <= ch_data[w_gnt*DATA_W +: DATA_W];
      end
      if (r_state == ACK) begin
        r_ptr[r_ch] <= r_ptr[r_ch] + PW'(1);
        r_last      <= r_ch;
        r_mask      <= w_onehot;
      end
    end
  end

  assign mem_addr = r_addr;
  assign mem_din  = r_din;
  assign ch_index = r_ch;

`ifdef TOF_MEM_WR_WRAP_FLAG_EN
  logic [N_CH-1:0] r_wrap;
  logic [N_CH-1:0] w_wrap_set;

  assign w_wrap_set = (r_state == ACK && r_ptr[r_ch] == '1)
                    ? w_onehot : '0;

  // Sticky wrap flags; a coincident set beats the clear
  always_ff @(posedge clk) begin
    if (!reset_n) r_wrap <= '0;
    else          r_wrap <= (r_wrap & ~wrap_clr) | w_wrap_set;
  end

  assign wrap_flag = r_wrap;
`endif

endmodule
